game_settings_ctrl: RTL

GAME_SETTINGS_CTRL -- requirements
Module: game_settings_ctrl

---
 rtl/game_settings_ctrl.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/game_settings_ctrl.sv
// game_settings_ctrl: settings-menu controller for a small game.
// It navigates between N_FIELDS numeric fields, edits the selected field in
// SETUP, and runs the SETUP/RUN/PAUSED/DONE state machine.
// Optional feature macro: AUTOREPEAT_EN. When it is defined, a held up/down
// button repeats its edit after REPEAT_DELAY cycles, then every REPEAT_PERIOD
// cycles.
// Every button action, and game_over, takes effect one clock after the input
// is first sampled high. Because start and game_over share the same latency,
// a coincident pair resolves in a single cycle.
module game_settings_ctrl #(
  parameter int                            N_FIELDS      = 2,
  parameter int                            FIELD_W       = 6,
  parameter logic [N_FIELDS*FIELD_W-1:0]   FIELD_MAX     = {6'd2, 6'd60},
  parameter logic [N_FIELDS*FIELD_W-1:0]   FIELD_STEP    = {6'd1, 6'd5},
  parameter logic [N_FIELDS-1:0]           FIELD_WRAP    = 2'b10,
  parameter int                            REPEAT_DELAY  = 50_000_000,
  parameter int                            REPEAT_PERIOD = 10_000_000
) (
  input  logic                             CLK100MHZ,
  input  logic                             CPU_RESETN,
  input  logic                             btn_up,
  input  logic                             btn_down,
  input  logic                             btn_left,
  input  logic                             btn_right,
  input  logic                             btn_start,
  input  logic                             game_over,
  output logic [N_FIELDS*FIELD_W-1:0]      fields,
  output logic [$clog2(N_FIELDS)-1:0]      sel,
  output logic [1:0]                       state,
  output logic                             running
);

  localparam int SEL_W = $clog2(N_FIELDS);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_FIELDS - 1);

  localparam int B_UP = 0;
  localparam int B_DN = 1;
  localparam int B_LT = 2;
  localparam int B_RT = 3;
  localparam int B_ST = 4;

  typedef enum logic [1:0] {
    ST_SETUP  = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  state_t             r_state;
  logic               r_running;
  logic [SEL_W-1:0]   r_sel;
  logic [4:0]         r_prev;
  logic [4:0]         r_lock;
  logic [4:0]         r_press;
  logic               r_game_over;

  logic [4:0]         w_btn;
  logic [4:0]         w_new;
  logic               w_rep_up;
  logic               w_rep_dn;
  logic               w_up_req;
  logic               w_dn_req;
  logic               w_edit_en;
  logic               w_sel_chg;

  assign w_btn = {btn_start, btn_right, btn_left, btn_down, btn_up};
  // r_lock suppresses a button that was already held when reset ended.
  // The button must be released before it can register a new press.
  assign w_new = w_btn & ~r_prev & ~r_lock;

  // Edge detection: register each fresh press and the game_over pulse.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_prev      <= '0;
      r_lock      <= '1;
      r_press     <= '0;
      r_game_over <= 1'b0;
    end else begin
      r_prev      <= w_btn;
      r_lock      <= r_lock & w_btn;
      r_press     <= w_new;
      r_game_over <= game_over;
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic             r_rep_active;
  logic             r_rep_dir;
  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep_up;
  logic             r_rep_dn;
  logic             w_hold_one;
  logic             w_hold_match;

  assign w_hold_one   = btn_up ^ btn_down;
  assign w_hold_match = r_rep_dir ? (btn_up & ~btn_down) : (btn_down & ~btn_up);

  // Auto-repeat: this starts on a lone up or down press in SETUP.
  // It is cancelled on release, on a sel change, or on leaving SETUP.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_rep_active <= 1'b0;
      r_rep_dir    <= 1'b0;
      r_rep_cnt    <= '0;
      r_rep_up     <= 1'b0;
      r_rep_dn     <= 1'b0;
    end else begin
      r_rep_up <= 1'b0;
      r_rep_dn <= 1'b0;
      if (r_state != ST_SETUP) begin
        r_rep_active <= 1'b0;
        r_rep_cnt    <= '0;
      end else if ((w_new[B_UP] ^ w_new[B_DN]) && w_hold_one) begin
        r_rep_active <= 1'b1;
        r_rep_dir    <= w_new[B_UP];
        r_rep_cnt    <= REP_W'(REPEAT_DELAY);
      end else if (r_rep_active && (!w_hold_match || w_sel_chg)) begin
        r_rep_active <= 1'b0;
        r_rep_cnt    <= '0;
      end else if (r_rep_active) begin
        if (r_rep_cnt == REP_W'(1)) begin
          r_rep_cnt <= REP_W'(REPEAT_PERIOD);
          r_rep_up  <= r_rep_dir;
          r_rep_dn  <= ~r_rep_dir;
        end else begin
          r_rep_cnt <= r_rep_cnt - REP_W'(1);
        end
      end
    end
  end

  assign w_rep_up = r_rep_up;
  assign w_rep_dn = r_rep_dn;
`else
  assign w_rep_up = 1'b0;
  assign w_rep_dn = 1'b0;
`endif

  assign w_up_req  = r_press[B_UP] | w_rep_up;
  assign w_dn_req  = r_press[B_DN] | w_rep_dn;
  assign w_edit_en = (r_state == ST_SETUP) && (w_up_req ^ w_dn_req);
  assign w_sel_chg = r_press[B_LT] ^ r_press[B_RT];

  // Field selection: left and right wrap around; pressing both cancels out.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_sel <= '0;
    end else if (w_sel_chg) begin
      if (r_press[B_RT]) r_sel <= (r_sel == SEL_LAST) ? '0 : r_sel + SEL_W'(1);
      else               r_sel <= (r_sel == '0) ? SEL_LAST : r_sel - SEL_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_FIELDS; gi++) begin : g_field
      localparam logic [FIELD_W-1:0] L_MAX  = FIELD_MAX[gi*FIELD_W +: FIELD_W];
      localparam logic [FIELD_W-1:0] L_STEP = FIELD_STEP[gi*FIELD_W +: FIELD_W];

      logic [FIELD_W-1:0] r_val;
      logic [FIELD_W:0]   w_sum;
      logic [FIELD_W-1:0] w_up_val;
      logic [FIELD_W-1:0] w_dn_val;
      logic               w_sel_hit;

      // The sum is one bit wider than the field, so a large step cannot
      // wrap silently before it is compared against the maximum.
      assign w_sum     = {1'b0, r_val} + {1'b0, L_STEP};
      assign w_sel_hit = (r_sel == SEL_W'(gi));

      if (FIELD_WRAP[gi]) begin : g_wrap
        assign w_up_val = (w_sum > {1'b0, L_MAX}) ? '0 : w_sum[FIELD_W-1:0];
        assign w_dn_val = (r_val < L_STEP) ? L_MAX : r_val - L_STEP;
      end else begin : g_sat
        assign w_up_val = (w_sum > {1'b0, L_MAX}) ? L_MAX : w_sum[FIELD_W-1:0];
        assign w_dn_val = (r_val < L_STEP) ? '0 : r_val - L_STEP;
      end

      // Field value: this field changes only when it is selected and editing is allowed.
      always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) r_val <= '0;
        else if (w_edit_en && w_sel_hit) r_val <= w_up_req ? w_up_val : w_dn_val;
      end

      assign fields[gi*FIELD_W +: FIELD_W] = r_val;
    end
  endgenerate

  // Game state machine: running is registered alongside the state.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_state   <= ST_SETUP;
      r_running <= 1'b0;
    end else begin
      case (r_state)
        ST_SETUP: if (r_press[B_ST] && (fields[FIELD_W-1:0] != '0)) begin
          r_state   <= ST_RUN;
          r_running <= 1'b1;
        end
        ST_RUN: if (r_game_over) begin
          r_state   <= ST_DONE;
          r_running <= 1'b0;
        end else if (r_press[B_ST]) begin
          r_state   <= ST_PAUSED;
          r_running <= 1'b0;
        end
        ST_PAUSED: if (r_press[B_ST]) begin
          r_state   <= ST_RUN;
          r_running <= 1'b1;
        end
        default: if (r_press[B_ST]) begin
          r_state   <= ST_SETUP;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign sel     = r_sel;
  assign state   = r_state;
  assign running = r_running;

endmodule
